// File: rtl/mips_pkg.sv
// Shared definitions for the multicycle MIPS core: memory-stage states,
// access kinds and the opcode constants decoded by control_unit.
package mips_pkg;

  // States of the memory-access handshake
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQ     = 2'd1,
    WAIT_RD = 2'd2,
    DONE    = 2'd3
  } state_t;

  // What the latched access will do with its result
  typedef enum logic [1:0] {
    KIND_FETCH = 2'd0,
    KIND_LOAD  = 2'd1,
    KIND_STORE = 2'd2
  } access_kind_t;

  // Opcodes understood by the core
  localparam logic [5:0] R_TYPE = 6'h00;
  localparam logic [5:0] J      = 6'h02;
  localparam logic [5:0] BEQ    = 6'h04;
  localparam logic [5:0] BNE    = 6'h05;
  localparam logic [5:0] ADDI   = 6'h08;
  localparam logic [5:0] LW     = 6'h23;
  localparam logic [5:0] SW     = 6'h2B;

endpackage

// File: rtl/mem_port.sv
// Memory-access stage: turns the control unit's level-held memory strobes
// into one request/grant/valid transaction per control state and captures
// read results in IR (fetch) or MDR (load).
module mem_port
  import mips_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] pc,
  input  logic [ADDR_W-1:0] alu_out,
  input  logic [DATA_W-1:0] write_data,
  input  logic              IorD,
  input  logic              IRWrite,
  input  logic              MemRead,
  input  logic              MemWrite,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_gnt,
  input  logic              mem_rvalid,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [DATA_W-1:0] instr,
  output logic [5:0]        opCode,
  output logic [DATA_W-1:0] mdr,
  output logic              mem_busy,
  output logic              mem_err
);

  state_t            state;
  access_kind_t      kind;
  logic              req_active;
  logic              req_invalid;
  logic              req_valid;
  logic [ADDR_W-1:0] addr;

  // A store may not be combined with a read, and only word addresses are legal
  assign req_active  = IRWrite | MemRead | MemWrite;
  assign addr        = IorD ? alu_out : pc;
  assign req_invalid = (addr[1:0] != 2'b00) | (MemWrite & (IRWrite | MemRead));
  assign req_valid   = req_active & ~req_invalid;

  assign opCode = instr[31:26];

  // Stall the control unit while an access is pending; never stall in reset
  always_comb begin
    mem_busy = 1'b0;
    if (reset) begin
      mem_busy = (state == IDLE && req_valid) || (state == REQ) || (state == WAIT_RD);
    end
  end

  // Handshake state machine with registered memory-side outputs and IR/MDR capture
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      kind      <= KIND_FETCH;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_err   <= 1'b0;
      instr     <= '0;
      mdr       <= '0;
    end else begin
      mem_err <= 1'b0;
      case (state)
        IDLE: begin
          if (req_active) begin
            if (req_invalid) begin
              mem_err <= 1'b1;
              state   <= DONE;
            end else begin
              mem_addr  <= addr;
              mem_wdata <= write_data;
              mem_we    <= MemWrite;
              mem_req   <= 1'b1;
              if (IRWrite) begin
                kind <= KIND_FETCH;
              end else if (MemRead) begin
                kind <= KIND_LOAD;
              end else begin
                kind <= KIND_STORE;
              end
              state <= REQ;
            end
          end
        end
        REQ: begin
          if (mem_gnt) begin
            mem_req <= 1'b0;
            mem_we  <= 1'b0;
            if (kind == KIND_STORE) begin
              state <= DONE;
            end else if (mem_rvalid) begin
              if (kind == KIND_FETCH) begin
                instr <= mem_rdata;
              end else begin
                mdr <= mem_rdata;
              end
              state <= DONE;
            end else begin
              state <= WAIT_RD;
            end
          end
        end
        WAIT_RD: begin
          if (mem_rvalid) begin
            if (kind == KIND_FETCH) begin
              instr <= mem_rdata;
            end else begin
              mdr <= mem_rdata;
            end
            state <= DONE;
          end
        end
        DONE: begin
          if (!req_active) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port.sv
// Directed testbench for mem_port: fetch, waited load, store, rejected
// requests, held strobes and asynchronous reset during an access.
module tb_mem_port;

  logic        clk;
  logic        reset;
  logic [31:0] pc;
  logic [31:0] alu_out;
  logic [31:0] write_data;
  logic        IorD;
  logic        IRWrite;
  logic        MemRead;
  logic        MemWrite;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_gnt;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;
  logic [31:0] instr;
  logic [5:0]  opCode;
  logic [31:0] mdr;
  logic        mem_busy;
  logic        mem_err;

  int checks;
  int failures;
  int busy_cycles;
  int req_cycles;

  mem_port #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk        (clk),
    .reset      (reset),
    .pc         (pc),
    .alu_out    (alu_out),
    .write_data (write_data),
    .IorD       (IorD),
    .IRWrite    (IRWrite),
    .MemRead    (MemRead),
    .MemWrite   (MemWrite),
    .mem_req    (mem_req),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_gnt    (mem_gnt),
    .mem_rvalid (mem_rvalid),
    .mem_rdata  (mem_rdata),
    .instr      (instr),
    .opCode     (opCode),
    .mdr        (mdr),
    .mem_busy   (mem_busy),
    .mem_err    (mem_err)
  );

  // Free-running clock, rising edges at 5, 15, 25 ...
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Advance to just after the next rising edge
  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  // Drive the strobes and memory responses for the current cycle, then settle
  task automatic applyStimulus(input logic ior_d, input logic ir_write,
                               input logic mem_read, input logic mem_write,
                               input logic gnt, input logic rvalid,
                               input logic [31:0] rdata);
    IorD       = ior_d;
    IRWrite    = ir_write;
    MemRead    = mem_read;
    MemWrite   = mem_write;
    mem_gnt    = gnt;
    mem_rvalid = rvalid;
    mem_rdata  = rdata;
    #1;
  endtask

  // Compare one observed value with its hand-computed expectation
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      failures++;
      $error("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, observed, expected);
    end
  endtask

  // Directed sequence
  initial begin
    checks     = 0;
    failures   = 0;
    reset      = 1'b0;
    pc         = 32'h0;
    alu_out    = 32'h0;
    write_data = 32'h0;
    IorD       = 1'b0;
    IRWrite    = 1'b0;
    MemRead    = 1'b0;
    MemWrite   = 1'b0;
    mem_gnt    = 1'b0;
    mem_rvalid = 1'b0;
    mem_rdata  = 32'h0;

    // Reset state
    nextCycle();
    nextCycle();
    checkOutput("rst_req",   {31'b0, mem_req}, 32'h0);
    checkOutput("rst_we",    {31'b0, mem_we},  32'h0);
    checkOutput("rst_err",   {31'b0, mem_err}, 32'h0);
    checkOutput("rst_addr",  mem_addr,  32'h0);
    checkOutput("rst_wdata", mem_wdata, 32'h0);
    checkOutput("rst_ir",    instr,     32'h0);
    checkOutput("rst_mdr",   mdr,       32'h0);
    checkOutput("rst_op",    {26'b0, opCode}, 32'h0);
    pc = 32'h40;
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    checkOutput("rst_busy_req", {31'b0, mem_busy}, 32'h0);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    reset = 1'b1;

    // Fetch, zero wait
    nextCycle();
    pc = 32'h40;
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    checkOutput("f_busy_c0", {31'b0, mem_busy}, 32'h1);
    checkOutput("f_req_c0",  {31'b0, mem_req},  32'h0);
    nextCycle();
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 32'h2008_0005);
    checkOutput("f_req_c1",  {31'b0, mem_req},  32'h1);
    checkOutput("f_addr_c1", mem_addr, 32'h40);
    checkOutput("f_we_c1",   {31'b0, mem_we},   32'h0);
    checkOutput("f_busy_c1", {31'b0, mem_busy}, 32'h1);
    nextCycle();
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    checkOutput("f_ir_c2",   instr, 32'h2008_0005);
    checkOutput("f_op_c2",   {26'b0, opCode}, 32'h08);
    checkOutput("f_busy_c2", {31'b0, mem_busy}, 32'h0);
    checkOutput("f_req_c2",  {31'b0, mem_req},  32'h0);
    nextCycle();
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);

    // Load with grant after three wait cycles and data two cycles after grant
    nextCycle();
    alu_out     = 32'h100;
    busy_cycles = 0;
    for (int k = 0; k < 10; k++) begin
      if (k > 0) nextCycle();
      applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, (k == 4), (k == 6 || k == 2),
                    (k == 6) ? 32'hDEAD_BEEF : ((k == 2) ? 32'hBAD0_BAD0 : 32'h0));
      if (mem_busy) busy_cycles++;
      if (k == 1) begin
        checkOutput("ld_addr", mem_addr, 32'h100);
        checkOutput("ld_req",  {31'b0, mem_req}, 32'h1);
      end
    end
    checkOutput("ld_busy_cycles", busy_cycles, 32'd7);
    checkOutput("ld_mdr", mdr,   32'hDEAD_BEEF);
    checkOutput("ld_ir",  instr, 32'h2008_0005);
    nextCycle();
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);

    // Store granted on the first request cycle
    nextCycle();
    alu_out    = 32'h104;
    write_data = 32'h1234_5678;
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
    checkOutput("st_busy_c0", {31'b0, mem_busy}, 32'h1);
    nextCycle();
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 32'h0);
    checkOutput("st_req",    {31'b0, mem_req}, 32'h1);
    checkOutput("st_we",     {31'b0, mem_we},  32'h1);
    checkOutput("st_wdata",  mem_wdata, 32'h1234_5678);
    checkOutput("st_addr",   mem_addr,  32'h104);
    checkOutput("st_busy_c1", {31'b0, mem_busy}, 32'h1);
    nextCycle();
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
    checkOutput("st_busy_c2", {31'b0, mem_busy}, 32'h0);
    checkOutput("st_req_c2",  {31'b0, mem_req},  32'h0);
    checkOutput("st_mdr", mdr,   32'hDEAD_BEEF);
    checkOutput("st_ir",  instr, 32'h2008_0005);
    nextCycle();
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);

    // Misaligned load is rejected
    nextCycle();
    alu_out = 32'h102;
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
    checkOutput("e1_busy_c0", {31'b0, mem_busy}, 32'h0);
    checkOutput("e1_err_c0",  {31'b0, mem_err},  32'h0);
    nextCycle();
    checkOutput("e1_err_c1",  {31'b0, mem_err},  32'h1);
    checkOutput("e1_req_c1",  {31'b0, mem_req},  32'h0);
    checkOutput("e1_busy_c1", {31'b0, mem_busy}, 32'h0);
    nextCycle();
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    checkOutput("e1_err_c2",  {31'b0, mem_err},  32'h0);

    // Store combined with fetch is rejected
    nextCycle();
    pc = 32'h40;
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
    checkOutput("e2_busy_c0", {31'b0, mem_busy}, 32'h0);
    nextCycle();
    checkOutput("e2_err_c1",  {31'b0, mem_err},  32'h1);
    checkOutput("e2_req_c1",  {31'b0, mem_req},  32'h0);
    nextCycle();
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    checkOutput("e2_err_c2",  {31'b0, mem_err},  32'h0);
    checkOutput("e2_ir", instr, 32'h2008_0005);

    // Held fetch strobe issues exactly one access
    nextCycle();
    pc          = 32'h80;
    busy_cycles = 0;
    req_cycles  = 0;
    for (int k = 0; k < 8; k++) begin
      if (k > 0) nextCycle();
      applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 32'h8C0A_0004);
      if (mem_busy) busy_cycles++;
      if (mem_req) req_cycles++;
    end
    checkOutput("hold_req_cycles",  req_cycles,  32'd1);
    checkOutput("hold_busy_cycles", busy_cycles, 32'd2);
    checkOutput("hold_ir", instr, 32'h8C0A_0004);
    checkOutput("hold_op", {26'b0, opCode}, 32'h23);
    nextCycle();
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);

    // Reset while the request is outstanding drops mem_req at once
    nextCycle();
    pc = 32'hC0;
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    nextCycle();
    checkOutput("rq_req_before", {31'b0, mem_req}, 32'h1);
    reset = 1'b0;
    #1;
    checkOutput("rq_req_async", {31'b0, mem_req}, 32'h0);
    checkOutput("rq_ir_async",  instr, 32'h0);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    reset = 1'b1;

    // Reset while waiting for read data; late data is ignored
    nextCycle();
    pc = 32'hC0;
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    nextCycle();
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0);
    nextCycle();
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    checkOutput("wr_busy_before", {31'b0, mem_busy}, 32'h1);
    reset = 1'b0;
    #1;
    checkOutput("wr_req",  {31'b0, mem_req},  32'h0);
    checkOutput("wr_ir",   instr, 32'h0);
    checkOutput("wr_busy", {31'b0, mem_busy}, 32'h0);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    reset = 1'b1;
    nextCycle();
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'hFFFF_FFFF);
    nextCycle();
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    checkOutput("wr_late_ir",  instr, 32'h0);
    checkOutput("wr_late_mdr", mdr,   32'h0);
    checkOutput("wr_late_busy", {31'b0, mem_busy}, 32'h0);

    // A fresh fetch after reset starts from IDLE
    nextCycle();
    pc = 32'h44;
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    checkOutput("post_busy_c0", {31'b0, mem_busy}, 32'h1);
    nextCycle();
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 32'h1000_0003);
    checkOutput("post_addr", mem_addr, 32'h44);
    nextCycle();
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    checkOutput("post_ir", instr, 32'h1000_0003);
    checkOutput("post_op", {26'b0, opCode}, 32'h04);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mem_port.md
# mem_port

Memory-access stage for the multicycle MIPS core. Sits between `control_unit` and a single shared instruction/data memory. Converts the control unit's level-held `IRWrite`/`MemRead`/`MemWrite`/`IorD` strobes into a registered request/grant/valid transaction, and captures results in the instruction register (IR) and memory data register (MDR). Raises `mem_busy` so the control unit holds its current state until the access completes.

## Interface
- `ADDR_W`, 32, byte-address width
- `DATA_W`, 32, data/instruction width; must be 32
- `clk`  in  1  sole clock; all state changes on rising edge
- `reset`  in  1  asynchronous, active-low; clears all state when low
- `pc`  in  ADDR_W  program counter, used when `IorD`=0
- `alu_out`  in  ADDR_W  ALUOut register, used when `IorD`=1
- `write_data`  in  DATA_W  B register, store data
- `IorD`  in  1  address select
- `IRWrite`  in  1  fetch request; result goes to IR
- `MemRead`  in  1  data-load request; result goes to MDR
- `MemWrite`  in  1  store request
- `mem_req`  out  1  request to memory, held until `mem_gnt`
- `mem_we`  out  1  1 = write
- `mem_addr`  out  ADDR_W  word-aligned address
- `mem_wdata`  out  DATA_W  store data
- `mem_gnt`  in  1  memory accepted the request this cycle
- `mem_rvalid`  in  1  read data valid this cycle
- `mem_rdata`  in  DATA_W  read data
- `instr`  out  DATA_W  IR contents
- `opCode`  out  6  `instr[31:26]`, feeds `control_unit`
- `mdr`  out  DATA_W  MDR contents
- `mem_busy`  out  1  stall to control unit, combinational
- `mem_err`  out  1  one-cycle pulse on a rejected request

## Operation
- States: IDLE, REQ, WAIT_RD, DONE.
- Request input is active when `IRWrite | MemRead | MemWrite` = 1.
- Address = `IorD ? alu_out : pc`.
- Invalid request: `addr[1:0]` != 0, or `MemWrite` together with `IRWrite` or `MemRead`.
- IDLE, valid request:
  - latch address, `write_data`, and kind (fetch / load / store); fetch wins if both `IRWrite` and `MemRead` are set;
  - go to REQ.
- IDLE, invalid request:
  - pulse `mem_err` for one cycle; no memory access;
  - go to DONE.
- REQ:
  - `mem_req`=1; `mem_addr`/`mem_we`/`mem_wdata` stay stable until `mem_gnt`.
  - On `mem_gnt`, store: go to DONE.
  - On `mem_gnt`, read: go to WAIT_RD. If `mem_rvalid` is also 1 that cycle, capture the data and go directly to DONE.
- WAIT_RD: on `mem_rvalid`, load `mem_rdata` into IR (fetch) or MDR (load), then go to DONE. `mem_rvalid` in any other state is ignored.
- DONE:
  - stay until the request input is 0, then go to IDLE;
  - this prevents re-issuing while the control unit is still in the same state.
- `mem_busy` = (IDLE & valid request) | REQ | WAIT_RD. It is 0 in DONE, so the control unit advances.
- IR and MDR change only on capture. They hold their value otherwise.

## Timing
- Reset values: state IDLE; `mem_req`, `mem_we`, `mem_err` = 0; `mem_addr`, `mem_wdata`, IR, MDR = 0; `opCode` = 0. `mem_busy` = 0 while `reset` is low.
- Reset asserted mid-access: `mem_req` drops immediately (asynchronously). The in-flight transaction is abandoned, and a late `mem_rvalid` after reset is ignored.
- `mem_req`, `mem_we`, `mem_addr`, `mem_wdata` are registered outputs.
- Best-case read: request seen in cycle 0; `mem_req` high in cycle 1 with `mem_gnt` and `mem_rvalid`; IR/MDR valid in cycle 2; `mem_busy` high for cycles 0–1.
- Best-case write: `mem_busy` high for cycles 0–1, DONE in cycle 2.
- Each extra cycle of grant or valid delay adds one busy cycle. There is no timeout.
- `mem_err` is high in the cycle after the request is seen. `mem_busy` stays 0 for an invalid request.

## Structure
- Shared `mips_pkg`:
  - state enum;
  - opcode constants (`R_TYPE`, `ADDI`, `BEQ`, `BNE`, `J`, `LW`, `SW`), shared with `control_unit`;
  - access-kind encoding.
- Single flat module; no sub-module is warranted.

## Test plan
- Fetch, zero wait: `pc`=0x40, `IRWrite`=1, memory grants and returns 0x2008_0005 in the same cycle. Expect `mem_addr`=0x40, `mem_we`=0, IR=0x2008_0005 and `opCode`=0x08 in cycle 2, `mem_busy` high for exactly 2 cycles.
- Load with waits: `IorD`=1, `alu_out`=0x100, `MemRead`=1; `mem_gnt` after 3 cycles, `mem_rvalid` 2 cycles later with 0xDEAD_BEEF. Expect MDR=0xDEAD_BEEF, IR unchanged, `mem_busy` high for 7 cycles.
- Store: `alu_out`=0x104, `write_data`=0x1234_5678, `MemWrite`=1, `mem_gnt` on the first `mem_req` cycle. Expect `mem_we`=1, `mem_wdata`=0x1234_5678, no IR/MDR change.
- Errors: `alu_out`=0x102 with `MemRead`=1, then `MemWrite`+`IRWrite` together. Expect a one-cycle `mem_err` for each, `mem_req` never asserted, `mem_busy`=0.
- Hold and reset:
  - Hold `IRWrite` for 5 cycles after DONE: exactly one fetch is issued.
  - Drop `reset` while in WAIT_RD: `mem_req`=0, IR=0, state IDLE; a following `mem_rvalid` is ignored.
